float_to_int_arbiter: RTL and testbench

Shares one combinational float_to_int converter between N_REQ requesters using round-robin arbitration. Each requester offers a 32-bit IEEE-754 single with a valid/ready handshake. The block registers the converted integer, the converter flags and the requester ID into a single output stage with valid/ready backpressure. It sits between the FP issue logic and any integer consumers, giving a single point of conversion for the design.

---
 rtl/float_to_int_pkg.sv | 41 ++++
 rtl/float_to_int.sv | 54 +++++
 rtl/float_to_int_arbiter.sv | 119 +++++++++++
 tb/tb_float_to_int_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_to_int_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float_to_int_pkg
// Description : Shared constants, flag indices and the saturation helper
//               used by the float-to-integer converter and its arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package float_to_int_pkg;

   localparam int FP_W     = 32;
   localparam int EXP_W    = 8;
   localparam int MAN_W    = 23;
   localparam int N_FLG    = 3;
   localparam int EXP_BIAS = 127;

   localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;
   localparam logic [FP_W-1:0]  SAT_POS      = 32'h7FFFFFFF;
   localparam logic [FP_W-1:0]  SAT_NEG      = 32'h80000000;

   // Bit positions inside the converter flag vector
   typedef enum logic [1:0] {
      FLG_DENORM  = 2'd0,
      FLG_PLOST   = 2'd1,
      FLG_INVALID = 2'd2
   } flag_e;

   // Saturated integer for an operand the converter rejected:
   // NaN maps to zero, everything else clamps toward its sign.
   function automatic logic [FP_W-1:0] sat_value(input logic [FP_W-1:0] op);
      logic is_nan;
      is_nan = (op[FP_W-2:MAN_W] == EXP_ALL_ONES) && (op[MAN_W-1:0] != '0);
      if (is_nan)
         sat_value = '0;
      else if (op[FP_W-1])
         sat_value = SAT_NEG;
      else
         sat_value = SAT_POS;
   endfunction

endpackage
`default_nettype wire

// File: rtl/float_to_int.sv
`default_nettype none
// ============================================================================
// Module      : float_to_int
// Description : Purely combinational IEEE-754 single to signed 32-bit
//               integer converter, rounding toward zero. Out-of-range and
//               NaN/Inf inputs raise invalid and return 0x80000000.
// Revision    : 1.0 - initial release
// ============================================================================
module float_to_int
   import float_to_int_pkg::*;
(
   input  logic [FP_W-1:0]  a,
   output logic [FP_W-1:0]  d,
   output logic [N_FLG-1:0] flags
);

   logic             sign;
   logic [EXP_W-1:0] expo;
   logic [MAN_W-1:0] man;
   logic [54:0]      shifted;   // 24-bit significand shifted by up to 30
   logic [FP_W-1:0]  mag;

   assign sign = a[FP_W-1];
   assign expo = a[FP_W-2:MAN_W];
   assign man  = a[MAN_W-1:0];

   // Truncating conversion with denorm / precision-lost / invalid detection
   always_comb begin
      d       = '0;
      flags   = '0;
      shifted = '0;
      mag     = '0;
      if (expo == EXP_ALL_ONES) begin
         flags[FLG_INVALID] = 1'b1;
         d                  = SAT_NEG;
      end else if (expo < 8'(EXP_BIAS)) begin
         // |value| < 1: result is zero, any nonzero input loses precision
         flags[FLG_DENORM] = (expo == '0) && (man != '0);
         flags[FLG_PLOST]  = (expo != '0) || (man != '0);
      end else if (expo >= 8'(EXP_BIAS + 31)) begin
         // Only exactly -2^31 is representable at this magnitude
         d = SAT_NEG;
         if (!(expo == 8'(EXP_BIAS + 31) && sign && man == '0))
            flags[FLG_INVALID] = 1'b1;
      end else begin
         shifted          = {31'b0, 1'b1, man} << (expo - 8'(EXP_BIAS));
         mag              = shifted[54:23];
         flags[FLG_PLOST] = |shifted[22:0];
         d                = sign ? -mag : mag;
      end
   end

endmodule
`default_nettype wire

// File: rtl/float_to_int_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : float_to_int_arbiter
// Description : Round-robin shares one float_to_int converter between
//               N_REQ requesters and registers the result, flags and owner
//               ID into a single valid/ready output stage. Also keeps a
//               saturating count of accepted invalid results.
//               Optional macro FTOI_SAT_EN: saturate out_d on invalid.
// Revision    : 1.0 - initial release
// ============================================================================
module float_to_int_arbiter
   import float_to_int_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ*FP_W-1:0] req_data,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ID_W-1:0]       out_id,
   output logic [FP_W-1:0]       out_d,
   output logic                  out_denorm,
   output logic                  out_p_lost,
   output logic                  out_invalid,
   output logic [CNT_W-1:0]      invalid_cnt
);

   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  grant;
   logic [ID_W-1:0]  next_ptr;
   logic             found;
   logic             can_load;
   logic [FP_W-1:0]  operand;
   logic [FP_W-1:0]  cvt_d;
   logic [FP_W-1:0]  load_d;
   logic [N_FLG-1:0] cvt_flags;

   // The output stage can take a new result when empty or being drained now
   assign can_load = !out_valid || out_ready;
   assign next_ptr = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;

   // Round-robin search: first valid requester at or after ptr, wrapping
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int k = 0; k < N_REQ; k++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i] && (((int'(ptr) + k) % N_REQ) == i)) begin
               found = 1'b1;
               grant = ID_W'(i);
            end
         end
      end
   end

   // One-hot grant and operand mux driven by the winning index
   always_comb begin
      req_ready = '0;
      operand   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant == ID_W'(i)) begin
            operand      = req_data[FP_W*i +: FP_W];
            req_ready[i] = !rst && can_load && found;
         end
      end
   end

   float_to_int u_cvt (
      .a     (operand),
      .d     (cvt_d),
      .flags (cvt_flags)
   );

   // Result value to register, optionally clamped when the converter rejects
   always_comb begin
      load_d = cvt_d;
`ifdef FTOI_SAT_EN
      if (cvt_flags[FLG_INVALID])
         load_d = sat_value(operand);
`endif
   end

   // Output stage, round-robin pointer and invalid-event counter
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_id      <= '0;
         out_d       <= '0;
         out_denorm  <= 1'b0;
         out_p_lost  <= 1'b0;
         out_invalid <= 1'b0;
         invalid_cnt <= '0;
         ptr         <= '0;
      end else begin
         if (out_valid && out_ready && out_invalid && (invalid_cnt != {CNT_W{1'b1}}))
            invalid_cnt <= invalid_cnt + 1'b1;
         if (can_load) begin
            if (found) begin
               out_valid   <= 1'b1;
               out_id      <= grant;
               out_d       <= load_d;
               out_denorm  <= cvt_flags[FLG_DENORM];
               out_p_lost  <= cvt_flags[FLG_PLOST];
               out_invalid <= cvt_flags[FLG_INVALID];
               ptr         <= next_ptr;
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_float_to_int_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_to_int_arbiter
// Description : Directed-vector bench for float_to_int_arbiter with a
//               real-arithmetic reference model and per-cycle comparison.
//               A second instance with a 2-bit counter covers saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_to_int_arbiter;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int CW  = 16;
`ifdef FTOI_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_valid = '0;
   logic [31:0]   din [N];
   logic [N*32-1:0] req_data;
   logic          out_ready = 1'b0;

   logic [N-1:0]  req_ready, req_ready2;
   logic          out_valid, out_valid2;
   logic [IDW-1:0] out_id, out_id2;
   logic [31:0]   out_d, out_d2;
   logic          out_denorm, out_denorm2, out_p_lost, out_p_lost2;
   logic          out_invalid, out_invalid2;
   logic [CW-1:0] invalid_cnt;
   logic [1:0]    invalid_cnt2;

   int total = 0;
   int bad   = 0;

   assign req_data = {din[3], din[2], din[1], din[0]};

   always #5 clk = ~clk;

   float_to_int_arbiter #(.N_REQ(N), .ID_W(IDW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_id(out_id), .out_d(out_d), .out_denorm(out_denorm),
      .out_p_lost(out_p_lost), .out_invalid(out_invalid),
      .invalid_cnt(invalid_cnt)
   );

   float_to_int_arbiter #(.N_REQ(N), .ID_W(IDW), .CNT_W(2)) dut_cnt2 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready2), .out_valid(out_valid2), .out_ready(out_ready),
      .out_id(out_id2), .out_d(out_d2), .out_denorm(out_denorm2),
      .out_p_lost(out_p_lost2), .out_invalid(out_invalid2),
      .invalid_cnt(invalid_cnt2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          mptr = 0;
   bit          mval = 1'b0;
   int          mid = 0;
   logic [31:0] md = '0;
   bit          mdn = 1'b0, mpl = 1'b0, minv = 1'b0;
   int          mcnt = 0, mcnt2 = 0;
   bit          live = 1'b0;

   function automatic int model_grant(input logic [N-1:0] v);
      for (int k = 0; k < N; k++)
         if (v[(mptr + k) % N]) return (mptr + k) % N;
      return -1;
   endfunction

   function automatic logic [31:0] clamp(input logic [31:0] a, input logic [31:0] raw);
      if (!SAT) return raw;
      if (a[30:23] == 8'hFF && a[22:0] != 0) return 32'h0;
      return a[31] ? 32'h80000000 : 32'h7FFFFFFF;
   endfunction

   // Value-level conversion: widen to double, truncate with $rtoi
   task automatic model_conv(input logic [31:0] a, output logic [31:0] d,
                             output bit dn, output bit pl, output bit inv);
      logic [63:0] db;
      real         r;
      int          iv;
      dn = 0; pl = 0; inv = 0; d = 0;
      if (a[30:23] == 8'hFF) begin
         inv = 1; d = clamp(a, 32'h80000000);
      end else if (a[30:23] == 8'h00) begin
         dn = (a[22:0] != 0); pl = dn;
      end else begin
         db = {a[31], 11'(int'(a[30:23]) + 896), a[22:0], 29'b0};
         r  = $bitstoreal(db);
         if (r >= 2147483648.0 || r < -2147483648.0) begin
            inv = 1; d = clamp(a, 32'h80000000);
         end else begin
            iv = $rtoi(r);
            d  = iv;
            pl = ($itor(iv) != r);
         end
      end
   endtask

   // Advance the model on each rising edge from the inputs seen there
   always @(posedge clk) begin : p_model
      int          g;
      logic [31:0] d;
      bit          dn, pl, inv;
      if (rst) begin
         mptr = 0; mval = 0; mid = 0; md = 0; mdn = 0; mpl = 0; minv = 0;
         mcnt = 0; mcnt2 = 0; live = 1;
      end else begin
         if (mval && out_ready && minv) begin
            if (mcnt < (1 << CW) - 1) mcnt++;
            if (mcnt2 < 3) mcnt2++;
         end
         if (!mval || out_ready) begin
            g = model_grant(req_valid);
            if (g >= 0) begin
               model_conv(din[g], d, dn, pl, inv);
               mval = 1; mid = g; md = d; mdn = dn; mpl = pl; minv = inv;
               mptr = (g + 1) % N;
            end else begin
               mval = 0;
            end
         end
      end
   end

   // Compare DUT against model every falling edge
   always @(negedge clk) begin : p_compare
      int           g;
      logic [N-1:0] er;
      if (live) begin
         er = '0;
         if (!rst && (!mval || out_ready)) begin
            g = model_grant(req_valid);
            if (g >= 0) er[g] = 1'b1;
         end
         check("m_req_ready", 32'(req_ready), 32'(er));
         check("m_out_valid", 32'(out_valid), 32'(mval));
         check("m_invalid_cnt", 32'(invalid_cnt), mcnt);
         check("m_invalid_cnt_w2", 32'(invalid_cnt2), mcnt2);
         if (mval) begin
            check("m_out_id", 32'(out_id), mid);
            check("m_out_d", out_d, md);
            check("m_flags", {29'b0, out_invalid, out_p_lost, out_denorm},
                  {29'b0, minv, mpl, mdn});
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_rr [4];
   logic [31:0] vec_in [5];
   logic [31:0] vec_d [5];
   logic        vec_inv [5];

   initial begin
      for (int i = 0; i < N; i++) din[i] = '0;
      exp_rr = '{32'd123, 32'hFFFFFFFB, 32'd1, 32'd0};
      vec_in = '{32'hFF800000, 32'h7F800000, 32'h4F000000, 32'hCF000000, 32'h4EFFFFFF};
      vec_d  = '{32'h80000000, SAT ? 32'h7FFFFFFF : 32'h80000000,
                 SAT ? 32'h7FFFFFFF : 32'h80000000, 32'h80000000, 32'h7FFFFF80};
      vec_inv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      rst = 1; tick(); tick();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_id", 32'(out_id), 0);
      check("rst_out_d", out_d, 0);
      check("rst_flags", {29'b0, out_invalid, out_p_lost, out_denorm}, 0);
      check("rst_cnt", 32'(invalid_cnt), 0);
      rst = 0;

      // Single request: 12.44 -> 12 with precision lost
      din[0] = 32'h41470A3D; req_valid = 4'b0001; out_ready = 1;
      #1 check("single_ready", 32'(req_ready), 32'h1);
      tick(); req_valid = 0;
      check("single_valid", 32'(out_valid), 1);
      check("single_d", out_d, 32'd12);
      check("single_plost", 32'(out_p_lost), 1);
      check("single_id", 32'(out_id), 0);
      tick();
      check("single_drain", 32'(out_valid), 0);

      // Fresh pointer, then all four requesters contending
      rst = 1; tick(); rst = 0;
      din[0] = 32'h42F71EB8; din[1] = 32'hC0A80000;
      din[2] = 32'h3F800000; din[3] = 32'h00400000;
      req_valid = 4'hF; out_ready = 1;
      for (int k = 0; k < 10; k++) begin
         #1 check("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
         tick();
         check("rr_id", 32'(out_id), k % 4);
         check("rr_d", out_d, exp_rr[k % 4]);
         check("rr_denorm", 32'(out_denorm), (k % 4) == 3 ? 1 : 0);
      end

      // Backpressure holds the result, the grant and the pointer
      out_ready = 0;
      #1 check("bp_ready", 32'(req_ready), 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp_valid", 32'(out_valid), 1);
         check("bp_id", 32'(out_id), 1);
         check("bp_d", out_d, 32'hFFFFFFFB);
      end
      out_ready = 1;
      #1 check("bp_resume", 32'(req_ready), 32'h4);
      tick();
      check("bp_resume_id", 32'(out_id), 2);

      // NaN accepted twice
      din[0] = 32'h7FC00000; req_valid = 4'b0001;
      tick();
      check("nan_inv", 32'(out_invalid), 1);
      check("nan_d", out_d, SAT ? 32'h0 : 32'h80000000);
      tick(); req_valid = 0;
      tick();
      check("nan_cnt", 32'(invalid_cnt), 2);

      // Infinities, overflow and the signed boundary
      for (int k = 0; k < 5; k++) begin
         din[2] = vec_in[k]; req_valid = 4'b0100;
         tick(); req_valid = 0;
         check("edge_d", out_d, vec_d[k]);
         check("edge_inv", 32'(out_invalid), 32'(vec_inv[k]));
         tick();
      end
      check("cnt_total", 32'(invalid_cnt), 5);
      check("cnt_sat_w2", 32'(invalid_cnt2), 3);

      // Reset while a result is stalled
      din[1] = 32'h3F800000; req_valid = 4'b0010; out_ready = 0;
      tick(); tick();
      check("stall_valid", 32'(out_valid), 1);
      req_valid = 4'hF; rst = 1;
      #1 check("rst_mid_ready", 32'(req_ready), 0);
      tick(); rst = 0;
      check("rst_mid_valid", 32'(out_valid), 0);
      check("rst_mid_cnt", 32'(invalid_cnt), 0);
      out_ready = 1;
      #1 check("rst_first_grant", 32'(req_ready), 32'h1);
      tick();
      check("rst_first_id", 32'(out_id), 0);
      req_valid = 0;
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
